// File: rtl/cpu_pkg.sv
// Constants shared by fetch, decode and datapath, plus the IF/ID
// load-source selector used by the fetch stage.
package cpu_pkg;
  localparam int INSTRUCTION_WIDTH = 18;
  localparam int PC_WIDTH          = 18;
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = '0;
  localparam logic [PC_WIDTH-1:0]          RESET_PC  = '0;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_SKID   = 2'd2,
    IFID_RESP   = 2'd3
  } ifid_sel_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr,pc} buffer that catches the memory response arriving
// while decode is stalled. Clear beats load, load beats drain.
module fetch_skid_buf #(
  parameter int IW = 18,
  parameter int PW = 18
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_drain,
  input  logic          i_clear,
  input  logic [IW-1:0] i_instr,
  input  logic [PW-1:0] i_pc,
  output logic          o_full,
  output logic [IW-1:0] o_instr,
  output logic [PW-1:0] o_pc
);
  logic          full_q;
  logic [IW-1:0] instr_q;
  logic [PW-1:0] pc_q;

  // Payload is only meaningful while full, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      full_q <= 1'b0;
    end else if (i_load) begin
      full_q  <= 1'b1;
      instr_q <= i_instr;
      pc_q    <= i_pc;
    end else if (i_drain) begin
      full_q <= 1'b0;
    end
  end

  assign o_full  = full_q;
  assign o_instr = instr_q;
  assign o_pc    = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem request/address, in-flight response
// tracking, skid buffer and the IF/ID register feeding decode.
module fetch_stage #(
  parameter int INSTRUCTION_WIDTH = cpu_pkg::INSTRUCTION_WIDTH,
  parameter int PC_WIDTH          = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]          RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  output logic                         o_imem_req,
  output logic [PC_WIDTH-1:0]          o_imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata,
  input  logic                         i_stallD,
  input  logic                         i_redirect,
  input  logic [PC_WIDTH-1:0]          i_redirect_pc,
  output logic [INSTRUCTION_WIDTH-1:0] o_instrD,
  output logic [PC_WIDTH-1:0]          o_pcD,
  output logic [PC_WIDTH-1:0]          o_pc_plus1D,
  output logic                         o_validD
);
  import cpu_pkg::*;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [PC_WIDTH-1:0]          pc_q;
  logic                         resp_v_q;
  logic [PC_WIDTH-1:0]          resp_pc_q;
  logic                         skid_full;
  logic [INSTRUCTION_WIDTH-1:0] skid_instr;
  logic [PC_WIDTH-1:0]          skid_pc;
  logic                         skid_load;
  logic                         skid_drain;
  ifid_sel_e                    ifid_sel;

  assign o_imem_addr = i_redirect ? i_redirect_pc : pc_q;
  // While stalled, only fetch if nothing is in flight or parked in the skid.
  assign o_imem_req  = !i_rst && (i_redirect || !i_stallD || (!skid_full && !resp_v_q));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q      <= RESET_PC;
      resp_v_q  <= 1'b0;
      resp_pc_q <= '0;
    end else begin
      if (o_imem_req) pc_q <= o_imem_addr + PC_ONE;
      resp_v_q  <= o_imem_req;
      resp_pc_q <= o_imem_addr;
    end
  end

  assign skid_load  = i_stallD && !i_redirect && resp_v_q;
  assign skid_drain = !i_stallD && !i_redirect;

  fetch_skid_buf #(
    .IW (INSTRUCTION_WIDTH),
    .PW (PC_WIDTH)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (skid_load),
    .i_drain (skid_drain),
    .i_clear (i_redirect),
    .i_instr (i_imem_rdata),
    .i_pc    (resp_pc_q),
    .o_full  (skid_full),
    .o_instr (skid_instr),
    .o_pc    (skid_pc)
  );

  // Skid content is older than the live response, so it goes first.
  always_comb begin
    ifid_sel = IFID_HOLD;
    if (i_redirect)     ifid_sel = IFID_BUBBLE;
    else if (!i_stallD) begin
      if (skid_full)     ifid_sel = IFID_SKID;
      else if (resp_v_q) ifid_sel = IFID_RESP;
      else               ifid_sel = IFID_BUBBLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_validD    <= 1'b0;
      o_instrD    <= NOP_INSTR;
      o_pcD       <= '0;
      o_pc_plus1D <= '0;
    end else begin
      case (ifid_sel)
        IFID_BUBBLE: begin
          o_validD <= 1'b0;
          o_instrD <= NOP_INSTR;
        end
        IFID_SKID: begin
          o_validD    <= 1'b1;
          o_instrD    <= skid_instr;
          o_pcD       <= skid_pc;
          o_pc_plus1D <= skid_pc + PC_ONE;
        end
        IFID_RESP: begin
          o_validD    <= 1'b1;
          o_instrD    <= i_imem_rdata;
          o_pcD       <= resp_pc_q;
          o_pc_plus1D <= resp_pc_q + PC_ONE;
        end
        default: ;
      endcase
    end
  end

  a_skid_resp_exclusive: assert property (@(posedge i_clk) disable iff (i_rst)
    !(skid_full && resp_v_q));
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an in-order delivery model checked every
// cycle, plus literal timing checks and a second instance for PC wrap.
module tb_fetch_stage;
  localparam int IW = 18;
  localparam int PW = 18;
  localparam logic [IW-1:0] NOP = '0;

  logic clk = 1'b0;
  logic rst = 1'b1, stall = 1'b0, redir = 1'b0;
  logic [PW-1:0] tgt = '0;

  logic          req, vld, req2, vld2;
  logic [PW-1:0] addr, pcd, p1d, addr2, pcd2, p1d2;
  logic [IW-1:0] rdata, instr, rdata2, instr2;
  logic          zero1 = 1'b0;
  logic [PW-1:0] zero_pc = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem(input logic [PW-1:0] a);
    logic [PW-1:0] s;
    s = a + 18'h100;
    return s;
  endfunction

  always @(posedge clk) if (req)  rdata  <= mem(addr);
  always @(posedge clk) if (req2) rdata2 <= mem(addr2);

  fetch_stage dut (
    .i_clk(clk), .i_rst(rst), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_rdata(rdata), .i_stallD(stall), .i_redirect(redir),
    .i_redirect_pc(tgt), .o_instrD(instr), .o_pcD(pcd),
    .o_pc_plus1D(p1d), .o_validD(vld)
  );

  fetch_stage #(.RESET_PC(18'h3FFFF)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_rdata(rdata2), .i_stallD(zero1), .i_redirect(zero1),
    .i_redirect_pc(zero_pc), .o_instrD(instr2), .o_pcD(pcd2),
    .o_pc_plus1D(p1d2), .o_validD(vld2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Delivery model: decode must see one contiguous address stream that
  // restarts at RESET_PC or the redirect target, with data = mem(pc).
  logic          p_rst = 1'b1, p_stall = 1'b0, p_redir = 1'b0;
  logic [PW-1:0] p_tgt = '0;
  logic [PW-1:0] exp_pc = '0;
  logic [PW-1:0] exp_nx;
  logic          h_v;
  logic [IW-1:0] h_i;
  logic [PW-1:0] h_pc, h_p1;

  always @(negedge clk) begin
    if (rst) chk("m_req_in_rst", req, 0);
    else if (redir) begin
      chk("m_redir_addr", addr, tgt);
      chk("m_redir_req", req, 1);
    end
    if (p_rst) begin
      chk("m_rst_valid", vld, 0);
      chk("m_rst_instr", instr, NOP);
      chk("m_rst_pc", pcd, 0);
      chk("m_rst_p1", p1d, 0);
      exp_pc = 18'h0;
    end else if (p_redir) begin
      chk("m_redir_bubble", vld, 0);
      exp_pc = p_tgt;
    end else if (p_stall) begin
      chk("m_hold_valid", vld, h_v);
      chk("m_hold_instr", instr, h_i);
      chk("m_hold_pc", pcd, h_pc);
      chk("m_hold_p1", p1d, h_p1);
    end else if (vld) begin
      exp_nx = exp_pc + 18'd1;
      chk("m_stream_pc", pcd, exp_pc);
      chk("m_stream_instr", instr, mem(exp_pc));
      chk("m_stream_p1", p1d, exp_nx);
      exp_pc = exp_nx;
    end else begin
      chk("m_bubble_nop", instr, NOP);
    end
    p_rst = rst; p_stall = stall; p_redir = redir; p_tgt = tgt;
    h_v = vld; h_i = instr; h_pc = pcd; h_p1 = p1d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string name, input logic v, input logic [PW-1:0] pc);
    chk({name, "_valid"}, vld, v);
    if (v) begin
      chk({name, "_pc"}, pcd, pc);
      chk({name, "_instr"}, instr, mem(pc));
      chk({name, "_p1"}, p1d, pc + 18'd1);
    end
  endtask

  initial begin
    // 1: reset release and steady stream; dut_wrap covers PC wrap
    repeat (2) tick();
    rst = 1'b0; #1;
    chk("t1_req", req, 1);  chk("t1_addr", addr, 0);
    chk("t5_req", req2, 1); chk("t5_addr", addr2, 18'h3FFFF);
    tick(); out("t1_c2", 0, 0); chk("t5_c2_valid", vld2, 0);
    tick(); out("t1_c3", 1, 0);
    chk("t1_c3_instr_lit", instr, 18'h100);
    chk("t5_pc0", pcd2, 18'h3FFFF); chk("t5_p1_0", p1d2, 0); chk("t5_instr0", instr2, 18'h000FF);
    tick(); out("t1_c4", 1, 1); chk("t5_pc1", pcd2, 0); chk("t5_p1_1", p1d2, 1);
    tick(); out("t1_c5", 1, 2); chk("t5_pc2", pcd2, 1); chk("t5_valid2", vld2, 1);
    tick(); out("t1_c6", 1, 3);
    tick(); out("t1_c7", 1, 4);
    // 2: three-cycle stall while pc 4 is presented
    stall = 1'b1; #1; chk("t2_req_s0", req, 0);
    repeat (2) begin
      tick(); out("t2_hold", 1, 4); chk("t2_req_hold", req, 0);
    end
    tick(); stall = 1'b0; #1;
    out("t2_rel0", 1, 4); chk("t2_req_rel", req, 1); chk("t2_addr_rel", addr, 6);
    tick(); out("t2_rel1", 1, 5);
    tick(); out("t2_rel2", 1, 6);
    // 3: redirect to 0x40
    redir = 1'b1; tgt = 18'h40; #1;
    chk("t3_req", req, 1); chk("t3_addr", addr, 18'h40);
    tick(); redir = 1'b0; out("t3_n1", 0, 0);
    tick(); out("t3_n2", 1, 18'h40);
    tick(); out("t3_n3", 1, 18'h41);
    // 4: redirect during stall with the skid full
    stall = 1'b1;
    tick(); out("t4_skid", 1, 18'h41);
    redir = 1'b1; tgt = 18'h80; #1;
    chk("t4_req", req, 1); chk("t4_addr", addr, 18'h80);
    tick(); redir = 1'b0; #1;
    out("t4_bub0", 0, 0); chk("t4_req_stalled", req, 0);
    tick(); out("t4_bub1", 0, 0);
    stall = 1'b0; #1;
    chk("t4_req_rel", req, 1); chk("t4_addr_rel", addr, 18'h81);
    tick(); out("t4_tgt", 1, 18'h80);
    tick(); out("t4_tgt1", 1, 18'h81);
    // 6: reset mid-stream with the skid full and stall high
    stall = 1'b1;
    tick(); out("t6_pre", 1, 18'h81);
    rst = 1'b1; #1; chk("t6_req_rst", req, 0);
    tick(); rst = 1'b0; stall = 1'b0; #1;
    out("t6_r1", 0, 0);
    chk("t6_r1_pc", pcd, 0); chk("t6_r1_p1", p1d, 0); chk("t6_r1_instr", instr, NOP);
    chk("t6_req", req, 1); chk("t6_addr", addr, 0);
    tick(); out("t6_r2", 0, 0);
    tick(); out("t6_r3", 1, 0);
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
